// File: rtl/mac_request_scheduler_if.sv
// Handshake/control bundle between the sample sources, the MAC datapath and the request scheduler.
// master = scheduler side; slave = sources/datapath/consumer side.
interface mac_request_scheduler_if #(
    parameter int NREQ = 4,
    parameter int SELW = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            load_sample;
    logic            clear_accum;
    logic            accum_en;
    logic [SELW-1:0] mux_sel;
    logic            result_latch;
    logic            res_valid;
    logic            res_ready;
    logic [IDW-1:0]  res_id;
    logic            busy;

    modport master (
        input  req, res_ready,
        output grant, load_sample, clear_accum, accum_en, mux_sel,
               result_latch, res_valid, res_id, busy
    );

    modport slave (
        output req, res_ready,
        input  grant, load_sample, clear_accum, accum_en, mux_sel,
               result_latch, res_valid, res_id, busy
    );
endinterface

// File: rtl/mac_request_scheduler.sv
// Round-robin scheduler sharing one TAPS-tap MAC datapath among NREQ sources; MAC_SCHED_B2B_EN chains HOLD->CLEAR.
// Latency: grant+load_sample 1 cycle after req seen in IDLE, res_valid TAPS+3 cycles after; TAPS+4 cycles/txn (TAPS+3 with B2B).
// Backpressure: HOLD freezes every output until res_ready; new requests are only arbitrated at IDLE (or HOLD exit with B2B).
module mac_request_scheduler #(
    parameter int NREQ = 4,
    parameter int TAPS = 4,
    parameter int SELW = $clog2(TAPS),
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    mac_request_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [SELW-1:0] TAP_LAST = SELW'(TAPS - 1);

    state_t          state;
    logic [SELW-1:0] tap_cnt;
    logic [IDW-1:0]  rr_last;
    logic [NREQ-1:0] grant_q;
    logic            load_q;
    logic            clear_q;
    logic            accum_q;
    logic            latch_q;
    logic            valid_q;
    logic [IDW-1:0]  id_q;
    logic            busy_q;

    logic            arb_any;
    logic [IDW-1:0]  arb_winner;
    logic [IDW-1:0]  cand;
    logic            start_txn;

    // Search starts one past the previous winner so every source gets a turn.
    always_comb begin
        arb_any    = 1'b0;
        arb_winner = '0;
        cand       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(rr_last) + i) % NREQ);
            if (!arb_any && bus.req[cand]) begin
                arb_any    = 1'b1;
                arb_winner = cand;
            end
        end
    end

`ifdef MAC_SCHED_B2B_EN
    assign start_txn = arb_any && ((state == IDLE) || ((state == HOLD) && bus.res_ready));
`else
    assign start_txn = arb_any && (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tap_cnt <= '0;
            rr_last <= IDW'(NREQ - 1);
            grant_q <= '0;
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            accum_q <= 1'b0;
            latch_q <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            latch_q <= 1'b0;

            case (state)
                IDLE: ;
                CLEAR: begin
                    state   <= ACCUM;
                    accum_q <= 1'b1;
                    tap_cnt <= '0;
                end
                ACCUM: begin
                    if (tap_cnt == TAP_LAST) begin
                        state   <= LATCH;
                        accum_q <= 1'b0;
                        latch_q <= 1'b1;
                        tap_cnt <= '0;
                    end else begin
                        tap_cnt <= tap_cnt + SELW'(1);
                    end
                end
                LATCH: begin
                    state   <= HOLD;
                    valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the HOLD exit above when a back-to-back start is taken.
            if (start_txn) begin
                state   <= CLEAR;
                grant_q <= NREQ'(1) << arb_winner;
                rr_last <= arb_winner;
                id_q    <= arb_winner;
                load_q  <= 1'b1;
                clear_q <= 1'b1;
                tap_cnt <= '0;
                busy_q  <= 1'b1;
            end
        end
    end

    // mux_sel tracks the tap counter, which is 0 outside ACCUM.
    assign bus.grant        = grant_q;
    assign bus.load_sample  = load_q;
    assign bus.clear_accum  = clear_q;
    assign bus.accum_en     = accum_q;
    assign bus.mux_sel      = tap_cnt;
    assign bus.result_latch = latch_q;
    assign bus.res_valid    = valid_q;
    assign bus.res_id       = id_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mac_request_scheduler.sv
// Directed bench for mac_request_scheduler (NREQ=4, TAPS=4): per-cycle expected output trace plus result-id scoreboard.
module tb_mac_request_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_request_scheduler_if #(.NREQ(4), .SELW(2), .IDW(2)) bus ();

    mac_request_scheduler #(.NREQ(4), .TAPS(4), .SELW(2), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

`ifdef MAC_SCHED_B2B_EN
    localparam bit B2B = 1'b1;
    localparam int PERIOD = 7;
`else
    localparam bit B2B = 1'b0;
    localparam int PERIOD = 8;
`endif

    typedef struct packed {
        logic [3:0] grant;
        logic       ld;
        logic       clr;
        logic       acc;
        logic [1:0] sel;
        logic       latch;
        logic       vld;
        logic [1:0] id;
        logic       busy;
    } obs_t;

    obs_t       exp_q[$];
    logic [1:0] res_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc_no = 0;
    logic [1:0] model_id;
    obs_t       e_obs;
    obs_t       a_obs;
    logic [1:0] e_id;

    function automatic obs_t mk(input logic [3:0] g, input logic ld, input logic clr, input logic acc,
                                input logic [1:0] sel, input logic latch, input logic vld,
                                input logic [1:0] id, input logic busy);
        obs_t o;
        o.grant = g; o.ld = ld; o.clr = clr; o.acc = acc; o.sel = sel;
        o.latch = latch; o.vld = vld; o.id = id; o.busy = busy;
        return o;
    endfunction

    task automatic push_idle();
        exp_q.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, model_id, 1'b0));
    endtask

    // One transaction: optional leading IDLE cycle, CLEAR, 4 taps, LATCH, n_hold HOLD cycles.
    task automatic push_txn(input logic [1:0] id, input bit with_idle, input int n_hold);
        logic [3:0] g;
        g = 4'b0001 << id;
        if (with_idle) push_idle();
        exp_q.push_back(mk(g, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, id, 1'b1));
        for (int t = 0; t < 4; t++)
            exp_q.push_back(mk(g, 1'b0, 1'b0, 1'b1, 2'(t), 1'b0, 1'b0, id, 1'b1));
        exp_q.push_back(mk(g, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, id, 1'b1));
        for (int h = 0; h < n_hold; h++)
            exp_q.push_back(mk(g, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, id, 1'b1));
        res_q.push_back(id);
        model_id = id;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = 4'b0000;
        cyc(1);
        reset    = 1'b0;
        model_id = 2'd0;
    endtask

    // Monitor: consumes one expected trace entry per cycle and checks every accepted result.
    always @(negedge clk) begin
        cyc_no <= cyc_no + 1;
        a_obs = {bus.grant, bus.load_sample, bus.clear_accum, bus.accum_en, bus.mux_sel,
                 bus.result_latch, bus.res_valid, bus.res_id, bus.busy};
        if (exp_q.size() > 0) begin
            e_obs = exp_q.pop_front();
            n_vec++;
            if (a_obs !== e_obs) begin
                n_err++;
                $display("FAIL trace @cyc %0d: got grant=%b ld=%b clr=%b acc=%b sel=%0d latch=%b vld=%b id=%0d busy=%b, required grant=%b ld=%b clr=%b acc=%b sel=%0d latch=%b vld=%b id=%0d busy=%b",
                         cyc_no, a_obs.grant, a_obs.ld, a_obs.clr, a_obs.acc, a_obs.sel, a_obs.latch,
                         a_obs.vld, a_obs.id, a_obs.busy, e_obs.grant, e_obs.ld, e_obs.clr, e_obs.acc,
                         e_obs.sel, e_obs.latch, e_obs.vld, e_obs.id, e_obs.busy);
            end
        end
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            n_vec++;
            if (res_q.size() == 0) begin
                n_err++;
                $display("FAIL result @cyc %0d: got res_id=%0d, required no result", cyc_no, bus.res_id);
            end else begin
                e_id = res_q.pop_front();
                if (bus.res_id !== e_id) begin
                    n_err++;
                    $display("FAIL result @cyc %0d: got res_id=%0d, required %0d", cyc_no, bus.res_id, e_id);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.req       = 4'b0000;
        bus.res_ready = 1'b0;
        model_id      = 2'd0;
        cyc(2);
        reset = 1'b0;

        // Single request from source 1, full cycle-by-cycle trace.
        bus.req       = 4'b0010;
        bus.res_ready = 1'b1;
        push_txn(2'd1, 1'b1, 1);
        push_idle();
        cyc(1);
        bus.req = 4'b0000;
        cyc(8);

        // All sources requesting: 0,1,2,3,0.
        do_reset();
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++)
            push_txn(2'(j % 4), !B2B || (j == 0), 1);
        push_idle();
        cyc(1 + PERIOD * 4);
        bus.req = 4'b0000;
        cyc(8);

        // Consumer stalls HOLD for 5 cycles.
        bus.req       = 4'b0100;
        bus.res_ready = 1'b0;
        push_txn(2'd2, 1'b1, 6);
        push_idle();
        cyc(1);
        bus.req = 4'b0000;
        cyc(11);
        bus.res_ready = 1'b1;
        cyc(2);

        // Granted source drops req at tap 1; transaction still completes.
        bus.req = 4'b0001;
        push_txn(2'd0, 1'b1, 1);
        push_idle();
        cyc(3);
        bus.req = 4'b0000;
        cyc(6);

        // Reset at tap 2 abandons the transaction; priority restarts at source 0.
        bus.req = 4'b1000;
        push_idle();
        exp_q.push_back(mk(4'b1000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1));
        for (int t = 0; t < 3; t++)
            exp_q.push_back(mk(4'b1000, 1'b0, 1'b0, 1'b1, 2'(t), 1'b0, 1'b0, 2'd3, 1'b1));
        cyc(1);
        bus.req = 4'b0000;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        reset    = 1'b0;
        model_id = 2'd0;
        bus.req  = 4'b1001;
        push_txn(2'd0, 1'b1, 1);
        push_idle();
        cyc(1);
        bus.req = 4'b0000;
        cyc(8);

        // Source 3 wins, then rr_last=3 wraps so source 0 beats source 3.
        bus.req = 4'b1000;
        push_txn(2'd3, 1'b1, 1);
        push_idle();
        cyc(1);
        bus.req = 4'b0000;
        cyc(8);
        bus.req = 4'b1001;
        push_txn(2'd0, 1'b1, 1);
        push_idle();
        cyc(1);
        bus.req = 4'b0000;
        cyc(8);

        cyc(2);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL trace_drain: got %0d entries left, required 0", exp_q.size());
        end
        n_vec++;
        if (res_q.size() != 0) begin
            n_err++;
            $display("FAIL result_drain: got %0d results outstanding, required 0", res_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
